// File: rtl/seq_add_sub.sv
// seq_add_sub: multi-cycle adder/subtractor that works LSB-first, SLICE bits
// per clock, over WIDTH/SLICE cycles. Each slice is a ripple of full adders,
// and the carry is held in a register between cycles.
// Ports:
//   clk, rst_n       - clock and synchronous active-low reset
//   start            - request; accepted only in IDLE or DONE
//   sub, a, b, cin   - mode, operands and carry/borrow-in, sampled with start
//   busy, done       - busy while computing; done is a one-cycle completion pulse
//   s, cout, ovf, zero - registered result and flags, held until next completion
module seq_add_sub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  // Reject illegal parameter combinations at elaboration
  if ((WIDTH < 2) || (SLICE == 0) || ((WIDTH % SLICE) != 0)) begin : g_param_check
    $error("seq_add_sub: WIDTH must be >= 2 and divisible by SLICE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   acc;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  logic [SLICE-1:0]   sl_a;
  logic [SLICE-1:0]   sl_b;
  logic [SLICE-1:0]   sl_sum;
  logic               sl_cout;
  logic               sl_cmsb;
  logic               rc;
  logic [WIDTH-1:0]   acc_next;

  // Operands are shifted right each cycle, so the active slice is always the low bits
  assign sl_a = op_a[SLICE-1:0];
  assign sl_b = op_b[SLICE-1:0];

  // Ripple-carry slice; also captures the carry into the slice's top bit,
  // which on the last slice is the carry into the result MSB
  always_comb begin
    rc      = carry;
    sl_sum  = '0;
    sl_cmsb = 1'b0;
    for (int i = 0; i < int'(SLICE); i++) begin
      if (i == int'(SLICE) - 1) begin
        sl_cmsb = rc;
      end
      sl_sum[i] = sl_a[i] ^ sl_b[i] ^ rc;
      rc        = (sl_a[i] & sl_b[i]) | (rc & (sl_a[i] ^ sl_b[i]));
    end
    sl_cout = rc;
  end

  // Accumulator fills from the top: after N shifts it holds the full result
  assign acc_next = WIDTH'({sl_sum, acc} >> SLICE);

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtract as a + ~b + ~borrow_in
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? ~cin : cin;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= sl_cout;
          op_a  <= op_a >> SLICE;
          op_b  <= op_b >> SLICE;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N - 1)) begin
            s     <= acc_next;
            cout  <= sl_cout;
            ovf   <= sl_cmsb ^ sl_cout;
            zero  <= (acc_next == '0);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add_sub.sv
// tb_seq_add_sub: scoreboard bench for seq_add_sub with two instances
// (WIDTH=8/SLICE=1 and WIDTH=8/SLICE=4) sharing operand inputs and reset.
module tb_seq_add_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       cin;

  logic       busy_o [2];
  logic       done_o [2];
  logic [7:0] s_o    [2];
  logic       cout_o [2];
  logic       ovf_o  [2];
  logic       zero_o [2];

  always #5 clk = ~clk;

  seq_add_sub #(.WIDTH(8), .SLICE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_o[0]), .done(done_o[0]), .s(s_o[0]), .cout(cout_o[0]),
    .ovf(ovf_o[0]), .zero(zero_o[0])
  );

  seq_add_sub #(.WIDTH(8), .SLICE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_o[1]), .done(done_o[1]), .s(s_o[1]), .cout(cout_o[1]),
    .ovf(ovf_o[1]), .zero(zero_o[1])
  );

  typedef struct {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
    int         cyc;
  } exp_t;

  exp_t       q [2][$];
  logic [7:0] hold [2];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nslices(input int k);
    return (k == 0) ? 8 : 2;
  endfunction

  // Monitor: checks reset state, completion results/timing and result hold
  initial begin
    hold[0] = 8'h00;
    hold[1] = 8'h00;
    forever begin
      logic r;
      exp_t e;
      @(posedge clk);
      r = rst_n;
      #1;
      for (int k = 0; k < 2; k++) begin
        if (r !== 1'b1) begin
          n_vec++;
          if (busy_o[k] !== 1'b0 || done_o[k] !== 1'b0 || s_o[k] !== 8'h00 ||
              cout_o[k] !== 1'b0 || ovf_o[k] !== 1'b0 || zero_o[k] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state[%0d] cyc=%0d: busy=%b done=%b s=%h cout=%b ovf=%b zero=%b, required all 0",
                     k, cyc, busy_o[k], done_o[k], s_o[k], cout_o[k], ovf_o[k], zero_o[k]);
          end
          hold[k] = 8'h00;
        end else if (done_o[k] === 1'b1) begin
          n_vec++;
          if (q[k].size() == 0) begin
            n_err++;
            $display("FAIL unexpected_done[%0d] cyc=%0d: done=1 with no operation outstanding", k, cyc);
          end else begin
            e = q[k].pop_front();
            if (s_o[k] !== e.s || cout_o[k] !== e.cout || ovf_o[k] !== e.ovf ||
                zero_o[k] !== e.zero || cyc != e.cyc) begin
              n_err++;
              $display("FAIL result[%0d]: got s=%h cout=%b ovf=%b zero=%b cyc=%0d, required s=%h cout=%b ovf=%b zero=%b cyc=%0d",
                       k, s_o[k], cout_o[k], ovf_o[k], zero_o[k], cyc,
                       e.s, e.cout, e.ovf, e.zero, e.cyc);
            end
            hold[k] = e.s;
          end
        end else begin
          n_vec++;
          if (s_o[k] !== hold[k]) begin
            n_err++;
            $display("FAIL hold[%0d] cyc=%0d: s=%h, required %h", k, cyc, s_o[k], hold[k]);
          end
          if (q[k].size() > 0 && cyc > q[k][0].cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL missed_done[%0d]: no done by cyc=%0d, required at cyc=%0d",
                     k, cyc, q[k][0].cyc);
            void'(q[k].pop_front());
          end
        end
      end
    end
  end

  // Launch one operation and queue its hand-computed result
  task automatic issue(input int k, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic tsub, input logic tcin, input logic [7:0] es,
                       input logic ec, input logic eo, input logic ez);
    exp_t e;
    @(negedge clk);
    a = ta; b = tb_v; sub = tsub; cin = tcin;
    start[k] = 1'b1;
    e.s = es; e.cout = ec; e.ovf = eo; e.zero = ez;
    e.cyc = cyc + 1 + nslices(k);
    q[k].push_back(e);
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  // Wait (bounded) for all outstanding operations to complete
  task automatic drain();
    int t = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d/%0d operations still outstanding, required 0/0",
               q[0].size(), q[1].size());
      q[0].delete();
      q[1].delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int   bc;
    exp_t e1;
    exp_t e2;
    rst_n = 1'b0; start = 2'b00; a = 8'h00; b = 8'h00; sub = 1'b0; cin = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Add with signed overflow; count busy cycles
    issue(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    bc = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy_o[0] === 1'b1) bc++;
      @(negedge clk);
    end
    n_vec++;
    if (bc != 8) begin
      n_err++;
      $display("FAIL busy_cycles: busy high %0d cycles, required 8", bc);
    end
    drain();

    // Subtraction: equal operands, then a borrow
    issue(0, 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    drain();
    issue(0, 8'h03, 8'h05, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
    drain();

    // SLICE=4 instance: wrap to zero, carry-in, borrow, borrow-in
    issue(1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    drain();
    issue(1, 8'h10, 8'h20, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    drain();
    issue(1, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    drain();
    issue(1, 8'h50, 8'h30, 1'b1, 1'b1, 8'h1F, 1'b1, 1'b0, 1'b0);
    drain();

    // start and operands disturbed mid-RUN must be ignored
    issue(0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; sub = 1'b1; cin = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; a = 8'h00;
    drain();

    // Reset at the third RUN edge aborts the operation
    issue(0, 8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    q[0].delete();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b0 || s_o[0] !== 8'h00 ||
        cout_o[0] !== 1'b0 || ovf_o[0] !== 1'b0 || zero_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL abort_reset: busy=%b done=%b s=%h cout=%b ovf=%b zero=%b, required all 0",
               busy_o[0], done_o[0], s_o[0], cout_o[0], ovf_o[0], zero_o[0]);
    end
    repeat (12) @(negedge clk);
    issue(0, 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0, 1'b0);
    drain();

    // start held high: back-to-back operations, one done per operation
    @(negedge clk);
    a = 8'h80; b = 8'h01; sub = 1'b1; cin = 1'b0; start[0] = 1'b1;
    e1.s = 8'h7F; e1.cout = 1'b1; e1.ovf = 1'b1; e1.zero = 1'b0; e1.cyc = cyc + 9;
    q[0].push_back(e1);
    @(negedge clk);
    a = 8'h40; b = 8'h40; sub = 1'b0;
    e2.s = 8'h80; e2.cout = 1'b0; e2.ovf = 1'b1; e2.zero = 1'b0; e2.cyc = e1.cyc + 9;
    q[0].push_back(e2);
    repeat (9) @(negedge clk);
    start[0] = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
